ex_mem_skid: RTL
================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of pc field.
REQ-002 SHALL have parameter DATA_W, default 32, width of vd field.
REQ-003 SHALL have parameter RADDR_W, default 5, width of rd field.
REQ-004 SHALL have parameter ZERO_RD_SUPPRESS, default 1, when 1 forces rd_enable to 0 for rd==0 at capture.
REQ-005 SHALL have port clk  in  1  single clock, all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port rdy  in  1  global ready; 0 freezes all state.
REQ-008 SHALL have port flush  in  1  discard all held entries.
REQ-009 SHALL have port ex_valid  in  1  upstream entry present.
REQ-010 SHALL have port ex_ready  out  1  block can accept this cycle.
REQ-011 SHALL have ports ex_pc  in  ADDR_W, ex_vd  in  DATA_W, ex_rd  in  RADDR_W, ex_rd_enable  in  1: upstream payload.
REQ-012 SHALL have port mem_valid  out  1  output entry present.
REQ-013 SHALL have port mem_ready  in  1  downstream accepts this cycle.
REQ-014 SHALL have ports mem_pc  out  ADDR_W, mem_vd  out  DATA_W, mem_rd  out  RADDR_W, mem_rd_enable  out  1: head payload.
REQ-015 SHALL have port count  out  2  number of held entries, 0..2.

Function
REQ-016 SHALL hold two entries: main (drives mem_* outputs) and skid; order preserved, main always older.
REQ-017 SHALL define accept = ex_valid & ex_ready & rdy, and release = mem_valid & mem_ready & rdy.
REQ-018 SHALL drive ex_ready = ~skid_valid directly from a register (no combinational path from mem_ready).
REQ-019 SHALL drive mem_valid = main_valid, registered.
REQ-020 SHALL drive mem_pc, mem_vd, mem_rd, mem_rd_enable to 0 whenever mem_valid=0.
REQ-021 SHALL give one-cycle latency: entry accepted at edge N appears on mem_* after edge N when main was empty or released at N.
REQ-022 SHALL, main empty and accept: load main from ex_*.
REQ-023 SHALL, main full, release and accept (skid empty): load main from ex_*.
REQ-024 SHALL, main full, no release, accept: load skid from ex_*; ex_ready low from next cycle.
REQ-025 SHALL, skid full and release: move skid into main, clear skid; ex_ready high from next cycle.
REQ-026 SHALL, main full, release, no accept, skid empty: clear main.
REQ-027 SHALL, when ZERO_RD_SUPPRESS=1 and ex_rd==0, store rd_enable=0; rd value stored unchanged.
REQ-028 SHALL keep count = main_valid + skid_valid, updated in same edge as entries.
REQ-029 SHALL, rdy=0 and flush=0: hold every register; no accept or release occurs regardless of valid/ready.
REQ-030 SHALL, flush=1 (any rdy): clear main and skid valids, count=0; same-cycle ex_* entry dropped; release in that cycle not counted.
REQ-031 SHALL never accept when full (count=2); ex_valid held high simply waits.

Reset
REQ-032 SHALL, rst=0 at an edge: clear main_valid, skid_valid, all payload registers, count=0; ex_ready=1 after that edge.
REQ-033 SHALL give rst priority over flush and rdy.
REQ-034 SHALL make reset mid-operation drop all held entries with no partial output.

Verification
REQ-035 SHALL cover: reset, then ex_valid=1 pc=0x100 vd=0xA rd=3 en=1, mem_ready=1 -> next cycle mem_valid=1, mem_pc=0x100, mem_rd_enable=1, count=1.
REQ-036 SHALL cover: mem_ready=0, push pc=0x10, 0x14, 0x18 back-to-back -> count=2, ex_ready=0 after second, 0x18 held off; mem_ready=1 -> outputs 0x10, 0x14, 0x18 in order, no loss.
REQ-037 SHALL cover: streaming with mem_ready=1 every cycle, 8 entries -> one output per cycle, count stays 1, ex_ready never drops.
REQ-038 SHALL cover: count=2 then flush=1 with ex_valid=1 pc=0x20 -> next cycle mem_valid=0, count=0, mem_* all 0, 0x20 never appears.
REQ-039 SHALL cover: rdy=0 for 3 cycles with ex_valid=1, mem_ready=1, count=1 -> state and outputs unchanged; resumes on rdy=1.
REQ-040 SHALL cover: ex_rd=0 en=1 with ZERO_RD_SUPPRESS=1 -> mem_rd=0, mem_rd_enable=0; also ADDR_W=16, DATA_W=64 build passes the same order test.

Source files
------------

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry EX->MEM pipeline register with skid buffer.
// The main entry drives the mem_* outputs; the skid entry catches one extra
// upstream entry so that ex_ready is a plain register and never depends
// combinationally on mem_ready.
module ex_mem_skid #(
   parameter int ADDR_W           = 32,
   parameter int DATA_W           = 32,
   parameter int RADDR_W          = 5,
   parameter int ZERO_RD_SUPPRESS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               flush,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [ADDR_W-1:0]  ex_pc,
   input  logic [DATA_W-1:0]  ex_vd,
   input  logic [RADDR_W-1:0] ex_rd,
   input  logic               ex_rd_enable,
   output logic               mem_valid,
   input  logic               mem_ready,
   output logic [ADDR_W-1:0]  mem_pc,
   output logic [DATA_W-1:0]  mem_vd,
   output logic [RADDR_W-1:0] mem_rd,
   output logic               mem_rd_enable,
   output logic [1:0]         count
);

   logic               main_valid, skid_valid;
   logic [ADDR_W-1:0]  main_pc, skid_pc;
   logic [DATA_W-1:0]  main_vd, skid_vd;
   logic [RADDR_W-1:0] main_rd, skid_rd;
   logic               main_en, skid_en;

   logic               main_valid_n, skid_valid_n;
   logic [ADDR_W-1:0]  main_pc_n, skid_pc_n;
   logic [DATA_W-1:0]  main_vd_n, skid_vd_n;
   logic [RADDR_W-1:0] main_rd_n, skid_rd_n;
   logic               main_en_n, skid_en_n;
   logic [1:0]         count_n;

   logic               acc, rel, cap_en;

   assign ex_ready  = ~skid_valid;
   assign mem_valid = main_valid;
   assign acc       = ex_valid & ~skid_valid & rdy;
   assign rel       = main_valid & mem_ready & rdy;
   assign cap_en    = ex_rd_enable & ~((ZERO_RD_SUPPRESS != 0) && (ex_rd == '0));

   // Next-state selection for the main/skid entries and the occupancy count.
   always_comb begin
      main_valid_n = main_valid;
      main_pc_n    = main_pc;
      main_vd_n    = main_vd;
      main_rd_n    = main_rd;
      main_en_n    = main_en;
      skid_valid_n = skid_valid;
      skid_pc_n    = skid_pc;
      skid_vd_n    = skid_vd;
      skid_rd_n    = skid_rd;
      skid_en_n    = skid_en;
      if (flush) begin
         main_valid_n = 1'b0;
         skid_valid_n = 1'b0;
      end else if (rdy) begin
         if (rel && skid_valid) begin
            // Skid full means ex_ready is low, so no accept can coincide.
            main_valid_n = 1'b1;
            main_pc_n    = skid_pc;
            main_vd_n    = skid_vd;
            main_rd_n    = skid_rd;
            main_en_n    = skid_en;
            skid_valid_n = 1'b0;
         end else begin
            if (rel) main_valid_n = 1'b0;
            if (acc) begin
               if (main_valid && !rel) begin
                  skid_valid_n = 1'b1;
                  skid_pc_n    = ex_pc;
                  skid_vd_n    = ex_vd;
                  skid_rd_n    = ex_rd;
                  skid_en_n    = cap_en;
               end else begin
                  main_valid_n = 1'b1;
                  main_pc_n    = ex_pc;
                  main_vd_n    = ex_vd;
                  main_rd_n    = ex_rd;
                  main_en_n    = cap_en;
               end
            end
         end
      end
      count_n = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         main_valid <= 1'b0;
         main_pc    <= '0;
         main_vd    <= '0;
         main_rd    <= '0;
         main_en    <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_vd    <= '0;
         skid_rd    <= '0;
         skid_en    <= 1'b0;
         count      <= '0;
      end else begin
         main_valid <= main_valid_n;
         main_pc    <= main_pc_n;
         main_vd    <= main_vd_n;
         main_rd    <= main_rd_n;
         main_en    <= main_en_n;
         skid_valid <= skid_valid_n;
         skid_pc    <= skid_pc_n;
         skid_vd    <= skid_vd_n;
         skid_rd    <= skid_rd_n;
         skid_en    <= skid_en_n;
         count      <= count_n;
      end
   end

   // Head payload is forced to zero whenever no entry is presented.
   always_comb begin
      mem_pc        = '0;
      mem_vd        = '0;
      mem_rd        = '0;
      mem_rd_enable = 1'b0;
      if (main_valid) begin
         mem_pc        = main_pc;
         mem_vd        = main_vd;
         mem_rd        = main_rd;
         mem_rd_enable = main_en;
      end
   end

endmodule
